dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_if.sv | 37 +++
 rtl/dmem_timeout_cnt.sv | 44 ++++
 rtl/dmem_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory controller.
//   ADDR_W / DATA_W  - core-side byte address and data widths
//   WORD_ADDR_W      - bus-side word address width (addr[31:2])
//   CNT_W            - timeout counter width, covers TIMEOUT_CYCLES up to 255
//   dmem_state_e     - controller FSM encoding
package dmem_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } dmem_state_e;

  // Word alignment test on a byte address.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: single-outstanding memory bus between the controller and data memory.
//   bus_req   - request, held for the whole transaction
//   bus_we    - 1 = write, 0 = read
//   bus_addr  - word address
//   bus_wdata - write data
//   bus_ack   - one-cycle completion strobe from memory
//   bus_rdata - read data, valid with bus_ack
// master: the controller side; slave: the memory side.
interface dmem_if;
  import dmem_pkg::*;

  logic                   bus_req;
  logic                   bus_we;
  logic [WORD_ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0]      bus_wdata;
  logic                   bus_ack;
  logic [DATA_W-1:0]      bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: counts bus cycles spent waiting for an acknowledge.
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   clear_i   - force the count to zero (held while no transaction is pending)
//   enable_i  - advance the count by one this cycle
//   expired_o - high during the TIMEOUT_CYCLES-th waiting cycle
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // The count holds the number of already-elapsed waiting cycles, so the
  // current cycle is the last allowed one when the count reaches N-1.
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: stalls the core while a single load/store runs on the memory bus.
//   clk, rst_n     - clock, asynchronous active-low reset
//   mem_enable_n   - active-low access request from decode
//   mem_read_n     - active-low load qualifier
//   mem_write_n    - active-low store qualifier (wins over load)
//   addr, wdata    - byte address and store data
//   stall          - core holds PC/instruction while high
//   rdata          - load result, held until the next load/timeout/misalign
//   err            - one-cycle pulse on misaligned access or bus timeout
//   bus            - memory bus, master side
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_enable_n,
  input  logic              mem_read_n,
  input  logic              mem_write_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  dmem_if.master            bus
);

  dmem_state_e            state_q;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   we_q;
  logic [DATA_W-1:0]      rdata_q;

  logic req_valid, aligned, start, misalign, in_access, expired, timeout;

  assign req_valid = !mem_enable_n && (!mem_read_n || !mem_write_n);
  assign aligned   = is_aligned(addr);
  assign start     = (state_q == StIdle) && req_valid && aligned;
  assign misalign  = (state_q == StIdle) && req_valid && !aligned;
  assign in_access = (state_q == StAccess);
  // An ack arriving in the last allowed cycle still completes normally.
  assign timeout   = in_access && !bus.bus_ack && expired;

  dmem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (!in_access),
    .enable_i (in_access && !bus.bus_ack),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q  <= addr[ADDR_W-1:2];
            wdata_q <= wdata;
            we_q    <= !mem_write_n;
            state_q <= StAccess;
          end else if (misalign) begin
            rdata_q <= '0;
          end
        end
        StAccess: begin
          if (bus.bus_ack) begin
            if (!we_q) begin
              rdata_q <= bus.bus_rdata;
            end
            state_q <= StDone;
          end else if (expired) begin
            rdata_q <= '0;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Result-visible cycle; a request seen here is not accepted.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // stall/err look at live request inputs, so keep them quiet while in reset.
  assign stall         = rst_n && (start || in_access);
  assign err           = rst_n && (misalign || timeout);
  assign rdata         = rdata_q;
  assign bus.bus_req   = in_access;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule
